mem_word_arbiter: RTL and testbench
===================================

// Module: mem_word_arbiter
// PURPOSE
// - Shares the byte-wide data Memory (rw_mem/mem_addr/din/dout/mem_ref) between two 32-bit requesters.
// - Requester 0 is the CPU load/store stage; requester 1 is the loader/debug port.
// - Round-robin arbitration; each accepted word or byte access is sequenced as consecutive single-byte beats.
// - Byte order is big-endian: byte at addr is bits [31:24], matching the ProgramCache word assembly.
// PARAMETERS
// - ADDR_W      32  width of request and memory addresses
// - WORD_BYTES  4   beats per word access; cnt width = clog2(WORD_BYTES)
// PORTS
// - clk         in   1       system clock; all state updates on posedge
// - rst         in   1       synchronous, active-high reset
// - req_valid   in   2       per-port request valid; held until req_ready
// - req_ready   out  2       one-hot accept pulse; combinational, high only in IDLE
// - req_we      in   2       per-port: 1 = write, 0 = read
// - req_size    in   2       per-port: 1 = word (WORD_BYTES beats), 0 = byte (1 beat)
// - req_addr    in   2*ADDR_W  per-port base address; port p is [p*ADDR_W +: ADDR_W]
// - req_wdata   in   64      per-port write data; port p is [p*32 +: 32]; byte write uses [7:0]
// - resp_valid  out  1       one-cycle completion pulse
// - resp_port   out  1       port that owns the current/last transaction
// - resp_rdata  out  32      read result; byte read is zero-extended; 0 for writes
// - mem_rw      out  1       to Memory rw_mem: 1 = READ_VALID, 0 = WRITE_VALID
// - mem_addr    out  ADDR_W  to Memory mem_addr
// - mem_din     out  8       to Memory din
// - mem_dout    in   8       from Memory dout; valid after the negedge of the beat cycle
// - mem_ref     in   1       from Memory; FULL expected on every beat; latched into err_sticky
// - err_sticky  out  1       set if mem_ref == EMPTY at the posedge ending any beat; cleared only by rst
// BEHAVIOUR
// - States: IDLE -> XFER -> DONE -> IDLE. State is held in a 2-bit register.
// - Reset values:
//   - state = IDLE, cnt = 0, last_grant = 1 (port 0 wins the first tie).
//   - resp_valid = 0, resp_port = 0, resp_rdata = 0, err_sticky = 0.
//   - mem_rw = 1, mem_addr = 0, mem_din = 0.
// - IDLE:
//   - Grant goes to the single valid port. If both are valid, grant goes to ~last_grant.
//   - req_ready[grant] = 1 in the same cycle.
//   - On the accepting posedge, latch we/size/addr/wdata; last_grant = grant; resp_port = grant; cnt = 0; go to XFER.
//   - While idle, drive mem_rw = READ, mem_addr = 0. Idle reads are harmless. No write ever occurs outside XFER.
// - XFER (one beat per cycle):
//   - mem_addr = base + cnt, modulo 2^ADDR_W (wraps, no range check).
//   - mem_rw = ~we.
//   - mem_din = wdata[31-8*cnt -: 8] for a word, wdata[7:0] for a byte.
//   - On a read, at the posedge rdata = {rdata[23:0], mem_dout}, with rdata cleared on accept.
//   - last = (size ? WORD_BYTES-1 : 0). If cnt == last go to DONE, else cnt++.
// - DONE:
//   - resp_valid = 1 for exactly this cycle; resp_rdata = rdata (0 if write); then go to IDLE.
//   - req_ready stays 0, so the next grant comes one cycle later.
// - Latency, accept at cycle T:
//   - Word: beats at T+1..T+4, resp_valid at T+5.
//   - Byte: beat at T+1, resp_valid at T+2.
//   - Minimum issue interval: 6 cycles for words, 3 for bytes.
// - A requester dropping req_valid after accept has no effect; the transaction completes.
// - rst asserted mid-XFER returns to IDLE on the next posedge with no resp_valid.
//   - Bytes already written stay in Memory; there is no rollback.
// - resp_rdata holds its value until the next DONE.
// STRUCTURE
// - Shared package mem_defs.vh holds:
//   - `READ_VALID / `WRITE_VALID / `FULL / `EMPTY (moved out of Mem.v).
//   - State encodings ST_IDLE = 2'd0, ST_XFER = 2'd1, ST_DONE = 2'd2.
//   - SIZE_BYTE = 1'b0 and SIZE_WORD = 1'b1.
// - One sub-module: rr_arb2 (combinational grant from req_valid and last_grant; one-hot out).
// - The beat sequencer stays in mem_word_arbiter.
// TESTING (bench instantiates Memory and this block on the same clk)
// - Port0 word write 0x0b381705 @0x10, then word read @0x10
//   -> Memory[0x10..0x13] = 0b,38,17,05; resp_rdata = 0x0b381705 at T+5.
// - Port1 byte read @0x12 after the above -> resp_rdata = 0x00000017 and resp_port = 1 at T+2.
// - Both ports valid in the same IDLE cycle after reset
//   -> port0 granted first, port1 granted on the next IDLE, then alternates while both stay valid.
// - Port0 word write 0xa24875e9 @0xFFFFFFFE with ADDR_W = 32 -> beats to addresses FFFFFFFE, FFFFFFFF, 0, 1.
// - rst pulsed during beat 2 of a word write 0xc961f054 @0x20
//   -> Memory[0x20] = c9, Memory[0x21] = 61, 0x22/0x23 unchanged; no resp_valid; all outputs at reset values.
// - Memory model forced to mem_ref = EMPTY on one beat -> err_sticky = 1 and held until rst.

Source files
------------

// File: rtl/mem_word_arbiter_pkg.sv
// Shared definitions for the two-port byte-memory arbiter: memory control
// encodings, FSM state encoding, access size codes and a byte-pick helper.
package mem_word_arbiter_pkg;

  localparam logic READ_VALID  = 1'b1;
  localparam logic WRITE_VALID = 1'b0;
  localparam logic FULL        = 1'b1;
  localparam logic EMPTY       = 1'b0;

  localparam logic SIZE_BYTE = 1'b0;
  localparam logic SIZE_WORD = 1'b1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_XFER = 2'd1,
    ST_DONE = 2'd2
  } state_e;

  // Big-endian byte pick: index 0 is bits [31:24].
  function automatic logic [7:0] word_byte(input logic [31:0] w, input int unsigned idx);
    logic [31:0] shifted;
    shifted = w << (idx * 8);
    return shifted[31:24];
  endfunction

endpackage

// File: rtl/mem_word_arbiter_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins outright, a tie goes to
// the port that did not win last time.
module rr_arb2 (
  input  logic [1:0] valid,
  input  logic       last_grant,
  output logic [1:0] grant_oh,
  output logic       grant_idx
);

  always_comb begin
    grant_idx = (valid == 2'b11) ? ~last_grant : valid[1];
    grant_oh  = 2'b00;
    if (|valid) begin
      grant_oh = grant_idx ? 2'b10 : 2'b01;
    end
  end

endmodule

// File: rtl/mem_word_arbiter.sv
// Shares a byte-wide memory between two 32-bit requesters; each accepted
// word/byte access is played out as consecutive single-byte beats.
module mem_word_arbiter
  import mem_word_arbiter_pkg::*;
#(
  parameter int ADDR_W     = 32,
  parameter int WORD_BYTES = 4
) (
  input  logic                clk,
  input  logic                rst,
  // Handshake: a port holds req_valid (and its fields) until it sees its
  // req_ready bit; the accept happens on that posedge, and the result
  // arrives later as a single-cycle resp_valid pulse tagged by resp_port.
  input  logic [1:0]          req_valid,
  output logic [1:0]          req_ready,
  input  logic [1:0]          req_we,
  input  logic [1:0]          req_size,
  input  logic [2*ADDR_W-1:0] req_addr,
  input  logic [63:0]         req_wdata,
  output logic                resp_valid,
  output logic                resp_port,
  output logic [31:0]         resp_rdata,
  output logic                mem_rw,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [7:0]          mem_din,
  input  logic [7:0]          mem_dout,
  input  logic                mem_ref,
  output logic                err_sticky,
  output logic [1:0]          dbg_state
);

  localparam int CNT_W = (WORD_BYTES > 1) ? $clog2(WORD_BYTES) : 1;
  localparam logic [CNT_W-1:0] LAST_WORD = CNT_W'(WORD_BYTES - 1);

  state_e             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               last_grant_q, last_grant_d;
  logic               we_q, we_d;
  logic               size_q, size_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;
  logic [31:0]        wdata_q, wdata_d;
  logic [31:0]        rdata_q, rdata_d;
  logic               resp_port_q, resp_port_d;
  logic [31:0]        resp_rdata_q, resp_rdata_d;
  logic               err_q, err_d;

  logic [1:0]         grant_oh;
  logic               grant_idx;
  logic [CNT_W-1:0]   last_cnt;

  rr_arb2 u_arb (
    .valid      (req_valid),
    .last_grant (last_grant_q),
    .grant_oh   (grant_oh),
    .grant_idx  (grant_idx)
  );

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    last_grant_d = last_grant_q;
    we_d         = we_q;
    size_d       = size_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    resp_port_d  = resp_port_q;
    resp_rdata_d = resp_rdata_q;
    err_d        = err_q;
    req_ready    = 2'b00;
    resp_valid   = 1'b0;
    mem_rw       = READ_VALID;
    mem_addr     = '0;
    mem_din      = 8'h00;
    last_cnt     = (size_q == SIZE_WORD) ? LAST_WORD : '0;

    unique case (state_q)
      ST_IDLE: begin
        req_ready = grant_oh;
        if (|req_valid) begin
          we_d         = req_we[grant_idx];
          size_d       = req_size[grant_idx];
          addr_d       = grant_idx ? req_addr[2*ADDR_W-1:ADDR_W] : req_addr[ADDR_W-1:0];
          wdata_d      = grant_idx ? req_wdata[63:32] : req_wdata[31:0];
          rdata_d      = 32'h0;
          cnt_d        = '0;
          last_grant_d = grant_idx;
          resp_port_d  = grant_idx;
          state_d      = ST_XFER;
        end
      end
      ST_XFER: begin
        // Address wraps modulo 2^ADDR_W by plain truncation.
        mem_addr = addr_q + ADDR_W'(cnt_q);
        mem_rw   = ~we_q;
        mem_din  = (size_q == SIZE_WORD) ? word_byte(wdata_q, 32'(cnt_q)) : wdata_q[7:0];
        if (!we_q) begin
          rdata_d = {rdata_q[23:0], mem_dout};
        end
        if (mem_ref == EMPTY) begin
          err_d = 1'b1;
        end
        if (cnt_q == last_cnt) begin
          state_d      = ST_DONE;
          resp_rdata_d = we_q ? 32'h0 : rdata_d;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      ST_DONE: begin
        resp_valid = 1'b1;
        state_d    = ST_IDLE;
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      last_grant_q <= 1'b1;
      we_q         <= 1'b0;
      size_q       <= SIZE_BYTE;
      addr_q       <= '0;
      wdata_q      <= 32'h0;
      rdata_q      <= 32'h0;
      resp_port_q  <= 1'b0;
      resp_rdata_q <= 32'h0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      last_grant_q <= last_grant_d;
      we_q         <= we_d;
      size_q       <= size_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      resp_port_q  <= resp_port_d;
      resp_rdata_q <= resp_rdata_d;
      err_q        <= err_d;
    end
  end

  assign resp_port  = resp_port_q;
  assign resp_rdata = resp_rdata_q;
  assign err_sticky = err_q;
  assign dbg_state  = state_q;

endmodule

// File: tb/tb_mem_word_arbiter.sv
// Directed bench for mem_word_arbiter with a negedge-clocked byte memory
// model standing in for Memory on the same clock.
module tb_mem_word_arbiter;
  import mem_word_arbiter_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_ready;
  logic [1:0]  req_we = 2'b00;
  logic [1:0]  req_size = 2'b00;
  logic [63:0] req_addr = 64'h0;
  logic [63:0] req_wdata = 64'h0;
  logic        resp_valid;
  logic        resp_port;
  logic [31:0] resp_rdata;
  logic        mem_rw;
  logic [31:0] mem_addr;
  logic [7:0]  mem_din;
  logic [7:0]  mem_dout = 8'h00;
  logic        mem_ref = FULL;
  logic        err_sticky;
  logic [1:0]  dbg_state;

  int errors = 0;
  int checks = 0;

  logic [7:0] mem [logic [31:0]];

  mem_word_arbiter #(.ADDR_W(32), .WORD_BYTES(4)) dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_we     (req_we),
    .req_size   (req_size),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_port  (resp_port),
    .resp_rdata (resp_rdata),
    .mem_rw     (mem_rw),
    .mem_addr   (mem_addr),
    .mem_din    (mem_din),
    .mem_dout   (mem_dout),
    .mem_ref    (mem_ref),
    .err_sticky (err_sticky),
    .dbg_state  (dbg_state)
  );

  // Clock / reset
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [7:0] mem_rd(input logic [31:0] a);
    return mem.exists(a) ? mem[a] : 8'h00;
  endfunction

  always @(negedge clk) begin
    if (mem_rw == WRITE_VALID) mem[mem_addr] = mem_din;
    else mem_dout = mem_rd(mem_addr);
  end

  // Driver: issues one request and follows it beat by beat.
  task automatic run_xfer(input int port, input logic we, input logic size,
                          input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [31:0] exp_rdata, input int empty_beat,
                          input int rst_beat, input string tag);
    int beats;
    int waited;
    logic [31:0] w;
    logic [31:0] exp_addr;
    logic [7:0]  exp_din;
    beats = size ? 4 : 1;
    w = wdata;
    req_we[port] = we;
    req_size[port] = size;
    req_addr[port*32 +: 32] = addr;
    req_wdata[port*32 +: 32] = wdata;
    req_valid[port] = 1'b1;
    #1;
    waited = 0;
    while (req_ready[port] !== 1'b1 && waited < 20) begin
      @(posedge clk); #1;
      waited++;
    end
    checks++;
    if (req_ready[port] !== 1'b1) begin
      errors++;
      $display("FAIL %s_accept: req_ready=%b expected bit %0d set", tag, req_ready, port);
      req_valid[port] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[port] = 1'b0;
    for (int i = 0; i < beats; i++) begin
      exp_addr = addr + i;
      exp_din = size ? w[31-8*i -: 8] : w[7:0];
      checks++;
      if ({mem_rw, mem_addr, mem_din, resp_valid} !== {~we, exp_addr, exp_din, 1'b0}) begin
        errors++;
        $display("FAIL %s_beat%0d: rw=%b addr=%h din=%h rv=%b expected rw=%b addr=%h din=%h rv=0",
                 tag, i, mem_rw, mem_addr, mem_din, resp_valid, ~we, exp_addr, exp_din);
      end
      if (i == rst_beat) begin
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        return;
      end
      if (i == empty_beat) mem_ref = EMPTY;
      @(posedge clk); #1;
      mem_ref = FULL;
    end
    checks++;
    if ({resp_valid, resp_port, resp_rdata} !== {1'b1, port[0], exp_rdata}) begin
      errors++;
      $display("FAIL %s_resp: valid=%b port=%b rdata=%h expected valid=1 port=%0d rdata=%h",
               tag, resp_valid, resp_port, resp_rdata, port, exp_rdata);
    end
    @(posedge clk); #1;
    checks++;
    if ({resp_valid, resp_rdata} !== {1'b0, exp_rdata}) begin
      errors++;
      $display("FAIL %s_pulse: valid=%b rdata=%h expected valid=0 rdata=%h held",
               tag, resp_valid, resp_rdata, exp_rdata);
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if ({dbg_state, resp_valid, resp_port, resp_rdata, err_sticky, mem_rw, mem_addr, mem_din, req_ready}
        !== {ST_IDLE, 1'b0, 1'b0, 32'h0, 1'b0, 1'b1, 32'h0, 8'h00, 2'b00}) begin
      errors++;
      $display("FAIL reset_values: st=%0d rv=%b rp=%b rd=%h err=%b rw=%b addr=%h din=%h rdy=%b expected 0,0,0,0,0,1,0,0,00",
               dbg_state, resp_valid, resp_port, resp_rdata, err_sticky, mem_rw, mem_addr, mem_din, req_ready);
    end
    rst = 1'b0;
  endtask

  task automatic test_word_write_read();
    run_xfer(0, 1'b1, SIZE_WORD, 32'h10, 32'h0b381705, 32'h0, -1, -1, "word_wr");
    checks++;
    if ({mem_rd(32'h10), mem_rd(32'h11), mem_rd(32'h12), mem_rd(32'h13)} !== 32'h0b381705) begin
      errors++;
      $display("FAIL word_wr_mem: mem[10..13]=%h %h %h %h expected 0b 38 17 05",
               mem_rd(32'h10), mem_rd(32'h11), mem_rd(32'h12), mem_rd(32'h13));
    end
    run_xfer(0, 1'b0, SIZE_WORD, 32'h10, 32'h0, 32'h0b381705, -1, -1, "word_rd");
  endtask

  task automatic test_byte_read_port1();
    run_xfer(1, 1'b0, SIZE_BYTE, 32'h12, 32'h0, 32'h00000017, -1, -1, "byte_rd_p1");
  endtask

  task automatic test_round_robin();
    logic [1:0] grants [4];
    int gcyc [4];
    int ngr;
    int cyc;
    logic [31:0] exp_rd;
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    req_we = 2'b00;
    req_size = 2'b00;
    req_addr = {32'h13, 32'h10};
    req_valid = 2'b11;
    #1;
    ngr = 0;
    cyc = 0;
    while (ngr < 4 && cyc < 40) begin
      if (resp_valid === 1'b1 && ngr > 0) begin
        exp_rd = (grants[ngr-1] == 2'b10) ? 32'h05 : 32'h0b;
        checks++;
        if ({resp_port, resp_rdata} !== {grants[ngr-1][1], exp_rd}) begin
          errors++;
          $display("FAIL rr_resp%0d: port=%b rdata=%h expected port=%b rdata=%h",
                   ngr, resp_port, resp_rdata, grants[ngr-1][1], exp_rd);
        end
      end
      if (req_ready !== 2'b00) begin
        grants[ngr] = req_ready;
        gcyc[ngr] = cyc;
        ngr++;
      end
      @(posedge clk); #1;
      cyc++;
    end
    checks++;
    if (ngr != 4) begin
      errors++;
      $display("FAIL rr_count: grants=%0d expected 4", ngr);
    end else begin
      for (int i = 0; i < 4; i++) begin
        checks++;
        if (grants[i] !== ((i % 2 == 0) ? 2'b01 : 2'b10)) begin
          errors++;
          $display("FAIL rr_grant%0d: ready=%b expected %b", i, grants[i], (i % 2 == 0) ? 2'b01 : 2'b10);
        end
        if (i > 0) begin
          checks++;
          if (gcyc[i] - gcyc[i-1] != 3) begin
            errors++;
            $display("FAIL rr_gap%0d: interval=%0d expected 3", i, gcyc[i] - gcyc[i-1]);
          end
        end
      end
    end
    req_valid = 2'b00;
    repeat (3) @(posedge clk);
    #1;
  endtask

  task automatic test_addr_wrap();
    run_xfer(0, 1'b1, SIZE_WORD, 32'hFFFFFFFE, 32'ha24875e9, 32'h0, -1, -1, "wrap_wr");
    checks++;
    if ({mem_rd(32'hFFFFFFFE), mem_rd(32'hFFFFFFFF), mem_rd(32'h0), mem_rd(32'h1)} !== 32'ha24875e9) begin
      errors++;
      $display("FAIL wrap_mem: FFFFFFFE,FFFFFFFF,0,1=%h %h %h %h expected a2 48 75 e9",
               mem_rd(32'hFFFFFFFE), mem_rd(32'hFFFFFFFF), mem_rd(32'h0), mem_rd(32'h1));
    end
  endtask

  task automatic test_reset_mid_xfer();
    bit seen;
    mem[32'h20] = 8'h00;
    mem[32'h21] = 8'h00;
    mem[32'h22] = 8'h5a;
    mem[32'h23] = 8'ha5;
    run_xfer(0, 1'b0, SIZE_BYTE, 32'h11, 32'h0, 32'h00000038, -1, -1, "pre_rst_rd");
    run_xfer(1, 1'b1, SIZE_WORD, 32'h20, 32'hc961f054, 32'h0, -1, 1, "rst_mid");
    checks++;
    if ({dbg_state, resp_valid, resp_port, resp_rdata, mem_rw, mem_addr, mem_din}
        !== {ST_IDLE, 1'b0, 1'b0, 32'h0, 1'b1, 32'h0, 8'h00}) begin
      errors++;
      $display("FAIL rst_mid_outputs: st=%0d rv=%b rp=%b rd=%h rw=%b addr=%h din=%h expected 0,0,0,0,1,0,0",
               dbg_state, resp_valid, resp_port, resp_rdata, mem_rw, mem_addr, mem_din);
    end
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      if (resp_valid === 1'b1) seen = 1'b1;
      @(posedge clk); #1;
    end
    checks++;
    if (seen) begin
      errors++;
      $display("FAIL rst_mid_no_resp: resp_valid=1 seen expected none");
    end
    checks++;
    if ({mem_rd(32'h20), mem_rd(32'h21), mem_rd(32'h22), mem_rd(32'h23)} !== 32'hc9615aa5) begin
      errors++;
      $display("FAIL rst_mid_mem: mem[20..23]=%h %h %h %h expected c9 61 5a a5",
               mem_rd(32'h20), mem_rd(32'h21), mem_rd(32'h22), mem_rd(32'h23));
    end
  endtask

  task automatic test_err_sticky();
    mem_ref = EMPTY;
    repeat (2) @(posedge clk);
    #1;
    mem_ref = FULL;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_idle: err_sticky=%b expected 0", err_sticky);
    end
    run_xfer(0, 1'b0, SIZE_BYTE, 32'h10, 32'h0, 32'h0000000b, 0, -1, "err_rd");
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL err_set: err_sticky=%b expected 1", err_sticky);
    end
    run_xfer(1, 1'b0, SIZE_BYTE, 32'h13, 32'h0, 32'h00000005, -1, -1, "err_clean");
    checks++;
    if (err_sticky !== 1'b1) begin
      errors++;
      $display("FAIL err_hold: err_sticky=%b expected 1", err_sticky);
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    checks++;
    if (err_sticky !== 1'b0) begin
      errors++;
      $display("FAIL err_clear: err_sticky=%b expected 0", err_sticky);
    end
  endtask

  initial begin
    test_reset();
    test_word_write_read();
    test_byte_read_port1();
    test_round_robin();
    test_addr_wrap();
    test_reset_mid_xfer();
    test_err_sticky();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
